// File: rtl/psg_tone_bank.sv
// Programmable sound generator: NUM_CH square-wave tone channels with frame
// length, volume envelope and stereo pan, mixed into saturated registered outputs.
module psg_tone_bank #(
   parameter int NUM_CH = 4,
   parameter int FREQ_W = 11,
   parameter int OUT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              tick,
   input  logic              wr,
   input  logic [5:0]        addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic [OUT_W-1:0]  left,
   output logic [OUT_W-1:0]  right,
   output logic [NUM_CH-1:0] active
);

   localparam logic [7:0] OUT_MAX = 8'((1 << OUT_W) - 1);

   typedef struct packed {
      logic [FREQ_W-1:0] freq;
      logic [3:0]        vol;
      logic [1:0]        duty;
      logic              pan_l;
      logic              pan_r;
      logic [7:0]        length;
      logic [3:0]        env_period;
      logic              env_dir;
      logic              env_en;
      logic              act;
      logic [3:0]        phase;
      logic [FREQ_W-1:0] div_cnt;
      logic [3:0]        env_vol;
      logic [3:0]        env_div;
      logic [7:0]        len_cnt;
      logic              len_en;
   } chan_t;

   chan_t             ch_q [NUM_CH];
   chan_t             ch_d [NUM_CH];
   logic [NUM_CH-1:0] wr_sel;
   logic [NUM_CH-1:0] trig;
   logic [6:0]        sum_l;
   logic [6:0]        sum_r;

   function automatic logic [6:0] chan_sample(input chan_t ch);
      logic [3:0] high_lim;
      case (ch.duty)
         2'd0:    high_lim = 4'd2;
         2'd1:    high_lim = 4'd4;
         2'd2:    high_lim = 4'd8;
         default: high_lim = 4'd12;
      endcase
      return (ch.act && (ch.phase < high_lim)) ? {3'b000, ch.env_vol} : 7'd0;
   endfunction

   function automatic logic [OUT_W-1:0] sat(input logic [6:0] sum);
      logic [7:0] wide;
      wide = {1'b0, sum};
      return (wide > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : wide[OUT_W-1:0];
   endfunction

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         wr_sel[c] = ce && wr && (addr[5:3] == 3'(c));
         trig[c]   = wr_sel[c] && (addr[2:0] == 3'd1) && wdata[7];
         active[c] = ch_q[c].act;
      end
   end

   // NOTE: combinational next-state uses blocking '=' and starts from the
   // current state, so every field has a value on every path and no latch forms.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_d[c] = ch_q[c];
         if (ce) begin
            if (ch_q[c].div_cnt == ch_q[c].freq) begin
               ch_d[c].div_cnt = '0;
               ch_d[c].phase   = ch_q[c].phase + 4'd1;
            end else begin
               ch_d[c].div_cnt = ch_q[c].div_cnt + FREQ_W'(1);
            end

            // A trigger on this channel swallows the frame tick.
            if (tick && !trig[c]) begin
               if (ch_q[c].act && ch_q[c].len_en) begin
                  ch_d[c].len_cnt = ch_q[c].len_cnt - 8'd1;
                  if (ch_q[c].len_cnt == 8'd1) ch_d[c].act = 1'b0;
               end
               if (ch_q[c].act && ch_q[c].env_en && (ch_q[c].env_period != 4'd0)) begin
                  if (ch_q[c].env_div == ch_q[c].env_period - 4'd1) begin
                     ch_d[c].env_div = 4'd0;
                     if (ch_q[c].env_dir && (ch_q[c].env_vol != 4'hF))
                        ch_d[c].env_vol = ch_q[c].env_vol + 4'd1;
                     else if (!ch_q[c].env_dir && (ch_q[c].env_vol != 4'h0))
                        ch_d[c].env_vol = ch_q[c].env_vol - 4'd1;
                  end else begin
                     ch_d[c].env_div = ch_q[c].env_div + 4'd1;
                  end
               end
            end

            if (wr_sel[c]) begin
               case (addr[2:0])
                  3'd0: begin
                     ch_d[c].freq[7:0] = wdata;
                     ch_d[c].div_cnt   = '0;
                  end
                  3'd1: begin
                     ch_d[c].freq    = FREQ_W'({wdata[6:0], ch_q[c].freq[7:0]});
                     ch_d[c].div_cnt = '0;
                     if (wdata[7]) begin
                        ch_d[c].act     = 1'b1;
                        ch_d[c].phase   = 4'd0;
                        ch_d[c].env_vol = ch_q[c].vol;
                        ch_d[c].env_div = 4'd0;
                        ch_d[c].len_cnt = ch_q[c].length;
                        ch_d[c].len_en  = (ch_q[c].length != 8'd0);
                     end
                  end
                  3'd2: begin
                     ch_d[c].vol     = wdata[3:0];
                     ch_d[c].duty    = wdata[5:4];
                     ch_d[c].pan_l   = wdata[6];
                     ch_d[c].pan_r   = wdata[7];
                     ch_d[c].env_vol = wdata[3:0];
                  end
                  3'd3: ch_d[c].length = wdata;
                  3'd4: begin
                     ch_d[c].env_period = wdata[3:0];
                     ch_d[c].env_dir    = wdata[4];
                     ch_d[c].env_en     = wdata[5];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      sum_l = 7'd0;
      sum_r = 7'd0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_q[c].pan_l) sum_l = sum_l + chan_sample(ch_q[c]);
         if (ch_q[c].pan_r) sum_r = sum_r + chan_sample(ch_q[c]);
      end
   end

   // NOTE: the channel array is ordinary control state, not a RAM, so every
   // entry is reset; a note must never survive a reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
         left  <= '0;
         right <= '0;
      end else begin
         ch_q  <= ch_d;
         left  <= sat(sum_l);
         right <= sat(sum_r);
      end
   end

   always_comb begin
      rdata = 8'h00;
      for (int c = 0; c < NUM_CH; c++) begin
         if (addr[5:3] == 3'(c)) begin
            case (addr[2:0])
               3'd0:    rdata = ch_q[c].freq[7:0];
               3'd1:    rdata = {1'b0, 7'(ch_q[c].freq >> 8)};
               3'd2:    rdata = {ch_q[c].pan_r, ch_q[c].pan_l, ch_q[c].duty, ch_q[c].vol};
               3'd3:    rdata = ch_q[c].length;
               3'd4:    rdata = {2'b00, ch_q[c].env_en, ch_q[c].env_dir, ch_q[c].env_period};
               3'd5:    rdata = {ch_q[c].act, 3'b000, ch_q[c].env_vol};
               default: rdata = 8'h00;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_psg_tone_bank.sv
// Self-checking bench for psg_tone_bank: an 8-channel/6-bit instance for the
// main behaviour plus a 4-channel instance for out-of-range channel accesses.
module tb_psg_tone_bank;

   localparam int NUM_CH = 8;
   localparam int FREQ_W = 11;
   localparam int OUT_W  = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ce = 1'b1;
   logic              tick = 1'b0;
   logic              wr = 1'b0;
   logic [5:0]        addr = '0;
   logic [7:0]        wdata = '0;
   logic [7:0]        rdata;
   logic [OUT_W-1:0]  left;
   logic [OUT_W-1:0]  right;
   logic [NUM_CH-1:0] active;
   logic [7:0]        rdata4;
   logic [7:0]        left4;
   logic [7:0]        right4;
   logic [3:0]        active4;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];

   typedef struct {
      logic [7:0] ctrl;
      int         exp_l;
      int         exp_r;
   } duty_vec_t;

   duty_vec_t duty_tbl [4];

   always #5 clk = ~clk;

   psg_tone_bank #(.NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .reset(reset), .ce(ce), .tick(tick), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(rdata), .left(left), .right(right), .active(active)
   );

   psg_tone_bank #(.NUM_CH(4), .FREQ_W(11), .OUT_W(8)) dut4 (
      .clk(clk), .reset(reset), .ce(ce), .tick(tick), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(rdata4), .left(left4), .right(right4), .active(active4)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input int ch, input int r, input int d);
      addr  = 6'((ch << 3) | r);
      wdata = 8'(d);
      wr    = 1'b1;
      cyc();
      wr    = 1'b0;
   endtask

   task automatic rd_check(input string name, input int ch, input int r, input int exp);
      addr = 6'((ch << 3) | r);
      @(negedge clk);
      check(name, int'(rdata), exp);
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int m_cnt;
      int m_phase;
      int e;
      int cnt_hi_l, cnt_hi_r, cnt_bad;
      int v;
      int vol;

      duty_tbl[0] = '{ctrl: 8'h89, exp_l: 0, exp_r: 2};
      duty_tbl[1] = '{ctrl: 8'h59, exp_l: 4, exp_r: 0};
      duty_tbl[2] = '{ctrl: 8'hE9, exp_l: 8, exp_r: 8};
      duty_tbl[3] = '{ctrl: 8'hB9, exp_l: 0, exp_r: 12};

      // Reset state
      do_reset();
      check("reset_left", int'(left), 0);
      check("reset_right", int'(right), 0);
      check("reset_active", int'(active), 0);
      rd_check("reset_status0", 0, 5, 0);
      rd_check("reset_ctrl7", 7, 2, 0);

      // Register readback, trigger bit, reserved and out-of-range channels
      wr_reg(3, 0, 8'hAB);
      wr_reg(3, 1, 8'h85);
      rd_check("freq_lo_rd", 3, 0, 8'hAB);
      rd_check("freq_hi_rd", 3, 1, 8'h05);
      wr_reg(3, 6, 8'hFF);
      rd_check("reserved_rd", 3, 6, 0);
      wr_reg(3, 4, 8'h3A);
      rd_check("env_rd", 3, 4, 8'h3A);
      wr_reg(5, 2, 8'hE7);
      rd_check("ch5_ctrl_rd", 5, 2, 8'hE7);
      check("ch_oob_read", int'(rdata4), 0);
      wr_reg(1, 2, 8'h3C);
      addr = 6'((1 << 3) | 2);
      @(negedge clk);
      check("ch4_inrange_read", int'(rdata4), 8'h3C);

      // 50% tone on ch0, freq 3, pan L: scoreboard of left per cycle
      do_reset();
      wr_reg(0, 0, 8'h03);
      wr_reg(0, 2, 8'h6F);
      wr_reg(0, 1, 8'h80);
      m_cnt = 0;
      m_phase = 0;
      exp_q.push_back(15);
      for (int k = 0; k < 128; k++) begin
         cyc();
         e = exp_q.pop_front();
         check("tone_left", int'(left), e);
         check("tone_right", int'(right), 0);
         if (m_cnt == 3) begin
            m_cnt = 0;
            m_phase = (m_phase + 1) % 16;
         end else begin
            m_cnt++;
         end
         exp_q.push_back((m_phase < 8) ? 15 : 0);
      end
      check("tone_queue_depth", exp_q.size(), 1);

      // Duty sweep on ch1, freq 0
      do_reset();
      wr_reg(1, 2, duty_tbl[0].ctrl);
      wr_reg(1, 1, 8'h80);
      for (int i = 0; i < 4; i++) begin
         wr_reg(1, 2, duty_tbl[i].ctrl);
         cyc();
         cnt_hi_l = 0;
         cnt_hi_r = 0;
         cnt_bad  = 0;
         for (int k = 0; k < 16; k++) begin
            cyc();
            if (left == 9) cnt_hi_l++; else if (left != 0) cnt_bad++;
            if (right == 9) cnt_hi_r++; else if (right != 0) cnt_bad++;
         end
         check($sformatf("duty%0d_left_high", i), cnt_hi_l, duty_tbl[i].exp_l);
         check($sformatf("duty%0d_right_high", i), cnt_hi_r, duty_tbl[i].exp_r);
         check($sformatf("duty%0d_stray_level", i), cnt_bad, 0);
      end

      // Length timeout and untimed notes
      do_reset();
      wr_reg(0, 2, 8'h4F);
      wr_reg(0, 3, 8'h03);
      wr_reg(0, 1, 8'h80);
      check("len_active_start", int'(active[0]), 1);
      do_tick();
      check("len_tick1", int'(active[0]), 1);
      do_tick();
      check("len_tick2", int'(active[0]), 1);
      do_tick();
      check("len_tick3", int'(active[0]), 0);
      rd_check("len_status", 0, 5, 8'h0F);
      wr_reg(0, 3, 8'h00);
      wr_reg(0, 1, 8'h80);
      tick = 1'b1;
      repeat (100) cyc();
      tick = 1'b0;
      check("untimed_active", int'(active[0]), 1);

      // Envelope down from 5, period 2; then up from 14
      do_reset();
      wr_reg(0, 2, 8'h05);
      wr_reg(0, 4, 8'h22);
      wr_reg(0, 1, 8'h80);
      rd_check("env_start", 0, 5, 8'h85);
      for (int k = 1; k <= 12; k++) begin
         do_tick();
         v = 5 - k / 2;
         if (v < 0) v = 0;
         rd_check($sformatf("env_down_t%0d", k), 0, 5, 8'h80 | v);
      end
      wr_reg(0, 2, 8'h0E);
      wr_reg(0, 4, 8'h32);
      wr_reg(0, 1, 8'h80);
      do_tick();
      rd_check("env_up_t1", 0, 5, 8'h8E);
      do_tick();
      rd_check("env_up_t2", 0, 5, 8'h8F);
      do_tick();
      do_tick();
      rd_check("env_up_sat", 0, 5, 8'h8F);

      // All eight channels, both pans, 75% duty: mix saturates at 63
      do_reset();
      for (int c = 0; c < 8; c++) wr_reg(c, 2, 8'hFF);
      for (int c = 0; c < 4; c++) wr_reg(c, 1, 8'h80);
      check("mix3_left", int'(left), 45);
      cyc();
      check("mix4_left", int'(left), 60);
      check("mix4_right", int'(right), 60);
      for (int c = 4; c < 8; c++) wr_reg(c, 1, 8'h80);
      cyc();
      check("mix8_left_sat", int'(left), 63);
      check("mix8_right_sat", int'(right), 63);
      check("mix8_active", int'(active), 8'hFF);

      // Trigger and tick together with len_cnt = 1: trigger wins and reloads
      do_reset();
      wr_reg(0, 2, 8'h0F);
      wr_reg(0, 3, 8'h02);
      wr_reg(0, 1, 8'h80);
      do_tick();
      tick = 1'b1;
      wr_reg(0, 1, 8'h80);
      tick = 1'b0;
      check("trig_tick_active", int'(active[0]), 1);
      do_tick();
      check("trig_reload_t1", int'(active[0]), 1);
      do_tick();
      check("trig_reload_t2", int'(active[0]), 0);

      // Length expiry and CTRL write in the same cycle
      wr_reg(0, 3, 8'h01);
      wr_reg(0, 2, 8'h0F);
      wr_reg(0, 1, 8'h80);
      tick = 1'b1;
      wr_reg(0, 2, 8'h03);
      tick = 1'b0;
      check("expiry_ctrl_active", int'(active[0]), 0);
      rd_check("expiry_ctrl_status", 0, 5, 8'h03);

      // ce = 0 freezes counters and ignores writes and ticks
      do_reset();
      wr_reg(2, 3, 8'h01);
      wr_reg(2, 2, 8'h8F);
      wr_reg(2, 1, 8'h80);
      ce = 1'b0;
      repeat (5) cyc();
      check("ce0_right_hold", int'(right), 15);
      tick = 1'b1;
      wr_reg(2, 2, 8'h00);
      tick = 1'b0;
      repeat (3) cyc();
      check("ce0_right_hold2", int'(right), 15);
      check("ce0_tick_ignored", int'(active[2]), 1);
      ce = 1'b1;
      rd_check("ce0_write_ignored", 2, 2, 8'h8F);
      do_tick();
      check("ce1_tick_expires", int'(active[2]), 0);

      // Reset mid-note
      wr_reg(0, 2, 8'hFF);
      wr_reg(0, 1, 8'h80);
      cyc();
      cyc();
      check("pre_reset_left", int'(left), 15);
      reset = 1'b1;
      cyc();
      check("reset_mid_left", int'(left), 0);
      check("reset_mid_right", int'(right), 0);
      check("reset_mid_active", int'(active), 0);
      reset = 1'b0;
      rd_check("reset_mid_status", 0, 5, 0);
      repeat (20) cyc();
      check("post_reset_left", int'(left), 0);
      check("post_reset_right", int'(right), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
